// File: rtl/hotselect_sequencer_pkg.sv
// Shared definitions for the calculator command sequencer: opcode map,
// datapath geometry and sequencer state encoding.
package hotselect_sequencer_pkg;

  localparam int CALC_SEL_W = 16;
  localparam int CALC_OP_W  = $clog2(CALC_SEL_W);

  localparam logic [CALC_OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [CALC_OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [CALC_OP_W-1:0] OP_MUL  = 4'd2;
  localparam logic [CALC_OP_W-1:0] OP_DIV  = 4'd3;
  localparam logic [CALC_OP_W-1:0] OP_MOD  = 4'd4;
  localparam logic [CALC_OP_W-1:0] OP_AND  = 4'd5;
  localparam logic [CALC_OP_W-1:0] OP_OR   = 4'd6;
  localparam logic [CALC_OP_W-1:0] OP_XOR  = 4'd7;
  localparam logic [CALC_OP_W-1:0] OP_NOT  = 4'd8;
  localparam logic [CALC_OP_W-1:0] OP_SHL  = 4'd9;
  localparam logic [CALC_OP_W-1:0] OP_SHR  = 4'd10;
  localparam logic [CALC_OP_W-1:0] OP_NEG  = 4'd11;
  localparam logic [CALC_OP_W-1:0] OP_INC  = 4'd12;
  localparam logic [CALC_OP_W-1:0] OP_DEC  = 4'd13;
  localparam logic [CALC_OP_W-1:0] OP_CMP  = 4'd14;
  localparam logic [CALC_OP_W-1:0] OP_PASS = 4'd15;

  localparam logic [CALC_SEL_W-1:0] DEFAULT_MC_MASK = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/hotselect_sequencer_onehot_encoder.sv
// Opcode index to one-hot mux select; exactly one bit set for any index.
module onehot_encoder #(
  parameter int OP_W  = 4,
  parameter int SEL_W = 16
) (
  input  logic [OP_W-1:0]  idx,
  output logic [SEL_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < SEL_W; i++) begin
      onehot[i] = (idx == OP_W'(i));
    end
  end

endmodule

// File: rtl/hotselect_sequencer.sv
// Command-side driver for the one-hot datapath mux: accepts an opcode, holds the
// select for the op latency, captures the mux result and returns it.
module hotselect_sequencer
  import hotselect_sequencer_pkg::*;
#(
  parameter  int               DATA_W        = 32,
  parameter  int               SEL_W         = CALC_SEL_W,
  parameter  int               SETTLE_CYCLES = 1,
  parameter  logic [SEL_W-1:0] MC_MASK       = DEFAULT_MC_MASK,
  parameter  int               MC_LAT        = 8,
  localparam int               OP_W          = $clog2(SEL_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_opcode,
  output logic [SEL_W-1:0]  hotselect,
  input  logic [DATA_W-1:0] muxout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [OP_W-1:0]   rsp_opcode,
  output logic              busy,
  output logic [15:0]       op_count
);

  localparam int LAT_MAX = (MC_LAT > SETTLE_CYCLES) ? MC_LAT : SETTLE_CYCLES;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [OP_W-1:0]     opcode_q, opcode_d;
  logic [SEL_W-1:0]    hot_d, enc_sel;
  logic                rv_d;
  logic [DATA_W-1:0]   rd_d;
  logic [OP_W-1:0]     ro_d;
  logic [15:0]         oc_d;
  logic [CNT_W-1:0]    lat_m1;

  onehot_encoder #(
    .OP_W  (OP_W),
    .SEL_W (SEL_W)
  ) u_enc (
    .idx    (cmd_opcode),
    .onehot (enc_sel)
  );

  assign lat_m1    = MC_MASK[cmd_opcode] ? CNT_W'(MC_LAT - 1) : CNT_W'(SETTLE_CYCLES - 1);
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    opcode_d = opcode_q;
    hot_d    = hotselect;
    rv_d     = rsp_valid;
    rd_d     = rsp_data;
    ro_d     = rsp_opcode;
    oc_d     = op_count;
    // flush outranks both the command and the response handshakes
    if (flush) begin
      state_d = ST_IDLE;
      hot_d   = '0;
      rv_d    = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            opcode_d = cmd_opcode;
            hot_d    = enc_sel;
            cnt_d    = lat_m1;
            state_d  = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (cnt != '0) begin
            cnt_d = cnt - CNT_W'(1);
          end else begin
            rd_d    = muxout;
            ro_d    = opcode_q;
            rv_d    = 1'b1;
            hot_d   = '0;
            state_d = ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rv_d    = 1'b0;
            oc_d    = op_count + 16'd1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          hot_d   = '0;
          rv_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      opcode_q   <= '0;
      hotselect  <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_opcode <= '0;
      op_count   <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      opcode_q   <= opcode_d;
      hotselect  <= hot_d;
      rsp_valid  <= rv_d;
      rsp_data   <= rd_d;
      rsp_opcode <= ro_d;
      op_count   <= oc_d;
    end
  end

endmodule

// File: tb/tb_hotselect_sequencer.sv
// Self-checking bench for hotselect_sequencer: directed table, randomized ops
// against a transaction-level model, and reset/flush/wrap corner sequences.
module tb_hotselect_sequencer;

  localparam int          DATA_W = 32;
  localparam int          SEL_W  = 16;
  localparam int          OP_W   = 4;
  localparam int          MC_LAT = 8;
  localparam int          SETTLE = 1;
  localparam logic [15:0] MASK   = 16'h0080;

  logic              clk, rst_n, flush, cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
  logic [OP_W-1:0]   cmd_opcode, rsp_opcode;
  logic [SEL_W-1:0]  hotselect;
  logic [DATA_W-1:0] muxout, rsp_data;
  logic [15:0]       op_count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt;

  hotselect_sequencer #(
    .DATA_W        (DATA_W),
    .SEL_W         (SEL_W),
    .SETTLE_CYCLES (SETTLE),
    .MC_MASK       (MASK),
    .MC_LAT        (MC_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .hotselect  (hotselect),
    .muxout     (muxout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_opcode (rsp_opcode),
    .busy       (busy),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] data;
    int          rdelay;
    logic [15:0] exp_hot;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_of(input logic [3:0] op);
    return MASK[op] ? MC_LAT : SETTLE;
  endfunction

  // One complete transaction; expected select, hold length and captured value
  // come from the caller and from the muxout values this task itself drives.
  task automatic do_op(input logic [3:0] op, input int rdelay, input bit rnd,
                       input logic [31:0] dval, input logic [15:0] exp_hot, input int exp_lat);
    logic [31:0] last;
    int          held;
    chk("idle_hot", hotselect, 0);
    chk("idle_ready", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    rsp_ready  = (rdelay == 0);
    muxout     = rnd ? $urandom : dval;
    step;
    cmd_valid  = 1'b0;
    cmd_opcode = 4'($urandom);
    held = 0;
    last = muxout;
    while (hotselect != 0 && held < 40) begin
      chk("hot_value", hotselect, exp_hot);
      chk("drive_cmd_ready", cmd_ready, 0);
      chk("drive_rsp_valid", rsp_valid, 0);
      held++;
      if (rnd) muxout = $urandom;
      last = muxout;
      step;
    end
    chk("hold_len", held, exp_lat);
    muxout = ~last;
    for (int i = 0; i < rdelay; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, last);
      chk("bp_rsp_opcode", rsp_opcode, op);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_busy", busy, 1);
      step;
    end
    rsp_ready = 1'b1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, last);
    chk("rsp_opcode", rsp_opcode, op);
    step;
    rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("op_count", op_count, exp_cnt);
    chk("rsp_data_kept", rsp_data, last);
    chk("post_busy", busy, 0);
  endtask

  vec_t tbl [6];

  initial begin
    tbl[0] = '{op: 4'd3,  data: 32'hDEAD_BEEF, rdelay: 0, exp_hot: 16'h0008, exp_lat: 1};
    tbl[1] = '{op: 4'd7,  data: 32'h1234_5678, rdelay: 0, exp_hot: 16'h0080, exp_lat: 8};
    tbl[2] = '{op: 4'd5,  data: 32'hA5A5_A5A5, rdelay: 5, exp_hot: 16'h0020, exp_lat: 1};
    tbl[3] = '{op: 4'd15, data: 32'hCAFE_F00D, rdelay: 0, exp_hot: 16'h8000, exp_lat: 1};
    tbl[4] = '{op: 4'd15, data: 32'h0BAD_F00D, rdelay: 0, exp_hot: 16'h8000, exp_lat: 1};
    tbl[5] = '{op: 4'd0,  data: 32'h0000_0001, rdelay: 2, exp_hot: 16'h0001, exp_lat: 1};

    rst_n = 1'b0; flush = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0;
    rsp_ready = 1'b0; muxout = '0; exp_cnt = '0;
    #12;
    chk("rst_hot", hotselect, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step;

    for (int i = 0; i < 6; i++)
      do_op(tbl[i].op, tbl[i].rdelay, 1'b0, tbl[i].data, tbl[i].exp_hot, tbl[i].exp_lat);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (i % 5 == 0) op = 4'd7;
      do_op(op, $urandom_range(0, 3), 1'b1, '0, 16'(1) << op, lat_of(op));
    end

    // async reset in the middle of a multi-cycle op
    cmd_valid = 1'b1; cmd_opcode = 4'd7;
    step;
    cmd_valid = 1'b0;
    step; step;
    chk("pre_rst_hot", hotselect, 16'h0080);
    #2 rst_n = 1'b0;
    #1;
    chk("midop_rst_hot", hotselect, 0);
    chk("midop_rst_rsp_valid", rsp_valid, 0);
    chk("midop_rst_op_count", op_count, 0);
    chk("midop_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    exp_cnt = '0;

    // flush during DRIVE, with a competing command in the same cycle
    do_op(4'd2, 0, 1'b1, '0, 16'h0004, 1);
    cmd_valid = 1'b1; cmd_opcode = 4'd7;
    step;
    cmd_valid = 1'b0;
    step; step;
    chk("flush_pre_hot", hotselect, 16'h0080);
    flush = 1'b1; cmd_valid = 1'b1; cmd_opcode = 4'd2;
    step;
    flush = 1'b0; cmd_valid = 1'b0;
    chk("flush_hot", hotselect, 0);
    chk("flush_rsp_valid", rsp_valid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_cmd_ready", cmd_ready, 1);
    chk("flush_op_count", op_count, exp_cnt);
    step;
    chk("flush_cmd_dropped", busy, 0);
    chk("flush_cmd_dropped_hot", hotselect, 0);

    // flush in RESP beats a simultaneous response handshake
    cmd_valid = 1'b1; cmd_opcode = 4'd3;
    step;
    cmd_valid = 1'b0;
    step;
    chk("resp_flush_pre_rv", rsp_valid, 1);
    flush = 1'b1; rsp_ready = 1'b1;
    step;
    flush = 1'b0; rsp_ready = 1'b0;
    chk("resp_flush_rv", rsp_valid, 0);
    chk("resp_flush_op_count", op_count, exp_cnt);
    chk("resp_flush_busy", busy, 0);

    // op_count wrap from 16'hFFFF
    force dut.op_count = 16'hFFFF;
    step;
    release dut.op_count;
    exp_cnt = 16'hFFFF;
    chk("wrap_preload", op_count, 16'hFFFF);
    do_op(4'd9, 1, 1'b1, '0, 16'h0200, 1);
    chk("wrap_zero", op_count, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
